// File: rtl/scan_mux_n1_pkg.sv
// Shared constants for the scanning N:1 multiplexer.
package scan_mux_n1_pkg;
  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;
endpackage

// File: rtl/scan_mux_n1_if.sv
// Source-bank / consumer bus of the scanning N:1 multiplexer.
interface scan_mux_n1_if #(
  parameter int N_CH = 8,
  parameter int W    = 1
);
  localparam int SEL_W = $clog2(N_CH);

  logic                mode;
  logic [SEL_W-1:0]    sel_in;
  logic                load;
  logic                step;
  logic                hold;
  logic [N_CH*W-1:0]   A;
  logic [W-1:0]        F;
  logic [SEL_W-1:0]    sel_out;
  logic                valid;
  logic                wrap;
  logic                sel_err;

  modport master (
    output mode, sel_in, load, step, hold, A,
    input  F, sel_out, valid, wrap, sel_err
  );

  modport slave (
    input  mode, sel_in, load, step, hold, A,
    output F, sel_out, valid, wrap, sel_err
  );
endinterface

// File: rtl/scan_mux_n1_sel_counter.sv
// Select register with manual load / scan step / hold; next_sel, wrap and
// sel_err are the combinational post-edge values, registered by the top.
module scan_mux_n1_sel_counter
  import scan_mux_n1_pkg::*;
#(
  parameter int N_CH  = 8,
  parameter int SEL_W = $clog2(N_CH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mode,
  input  logic             load,
  input  logic             step,
  input  logic             hold,
  input  logic [SEL_W-1:0] sel_in,
  output logic [SEL_W-1:0] next_sel,
  output logic             wrap,
  output logic             sel_err
);
  localparam logic [SEL_W:0]   NCH  = (SEL_W+1)'(N_CH);
  localparam logic [SEL_W-1:0] LAST = SEL_W'(N_CH-1);

  logic [SEL_W-1:0] sel_q;

  always_comb begin
    next_sel = sel_q;
    wrap     = 1'b0;
    sel_err  = 1'b0;
    if (!hold) begin
      if (mode == MODE_MANUAL) begin
        if (load) begin
          // indices past N_CH-1 are rejected so F never reads padding bits
          if ({1'b0, sel_in} < NCH) next_sel = sel_in;
          else                      sel_err  = 1'b1;
        end
      end else if (step) begin
        if (sel_q == LAST) begin
          next_sel = '0;
          wrap     = 1'b1;
        end else begin
          next_sel = sel_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sel_q <= '0;
    else     sel_q <= next_sel;
  end
endmodule

// File: rtl/scan_mux_n1.sv
// Parametrised N:1 mux with registered output, manual select load and
// time-division scan stepping.
module scan_mux_n1
  import scan_mux_n1_pkg::*;
#(
  parameter int N_CH = 8,
  parameter int W    = 1
) (
  input logic         clk,
  input logic         rst,
  scan_mux_n1_if.slave bus
);
  localparam int SEL_W = $clog2(N_CH);

  logic [SEL_W-1:0] next_sel;
  logic             wrap_n;
  logic             err_n;

  scan_mux_n1_sel_counter #(.N_CH(N_CH), .SEL_W(SEL_W)) u_sel_counter (
    .clk      (clk),
    .rst      (rst),
    .mode     (bus.mode),
    .load     (bus.load),
    .step     (bus.step),
    .hold     (bus.hold),
    .sel_in   (bus.sel_in),
    .next_sel (next_sel),
    .wrap     (wrap_n),
    .sel_err  (err_n)
  );

  // F samples A at the same edge the select moves, so the new channel
  // shows up without an extra cycle of stale data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.F       <= '0;
      bus.sel_out <= '0;
      bus.valid   <= 1'b0;
      bus.wrap    <= 1'b0;
      bus.sel_err <= 1'b0;
    end else begin
      bus.wrap    <= wrap_n;
      bus.sel_err <= err_n;
      if (!bus.hold) begin
        bus.F       <= bus.A[int'(next_sel)*W +: W];
        bus.sel_out <= next_sel;
        bus.valid   <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_scan_mux_n1.sv
// Directed bench for scan_mux_n1: an 8-channel and a 5-channel instance.
module tb_scan_mux_n1;
  import scan_mux_n1_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  scan_mux_n1_if #(.N_CH(8), .W(4)) b8();
  scan_mux_n1_if #(.N_CH(5), .W(4)) b5();

  scan_mux_n1 #(.N_CH(8), .W(4)) dut8 (.clk(clk), .rst(rst), .bus(b8));
  scan_mux_n1 #(.N_CH(5), .W(4)) dut5 (.clk(clk), .rst(rst), .bus(b5));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk8(input string tag, input int f, input int s, input int v,
                      input int w);
    chk({tag, ".F"},       32'(b8.F),       f);
    chk({tag, ".sel_out"}, 32'(b8.sel_out), s);
    chk({tag, ".valid"},   32'(b8.valid),   v);
    chk({tag, ".wrap"},    32'(b8.wrap),    w);
    chk({tag, ".sel_err"}, 32'(b8.sel_err), 0);
  endtask

  task automatic chk5(input string tag, input int f, input int s, input int w,
                      input int e);
    chk({tag, ".F"},       32'(b5.F),       f);
    chk({tag, ".sel_out"}, 32'(b5.sel_out), s);
    chk({tag, ".wrap"},    32'(b5.wrap),    w);
    chk({tag, ".sel_err"}, 32'(b5.sel_err), e);
  endtask

  initial begin
    rst = 1'b1;
    b8.mode = MODE_MANUAL; b8.sel_in = '0; b8.load = 0; b8.step = 0; b8.hold = 0;
    b5.mode = MODE_MANUAL; b5.sel_in = '0; b5.load = 0; b5.step = 0; b5.hold = 0;
    for (int k = 0; k < 8; k++) b8.A[k*4 +: 4] = 4'(k + 8);
    for (int k = 0; k < 5; k++) b5.A[k*4 +: 4] = 4'(k + 1);
    #3;
    chk8("reset", 0, 0, 0, 0);

    // hold on the very first edge keeps valid low
    @(negedge clk);
    rst = 1'b0;
    b8.hold = 1; b5.hold = 1;
    tick;
    chk8("first_hold", 0, 0, 0, 0);
    b8.hold = 0; b5.hold = 0;

    // manual load of channel 3
    b8.load = 1; b8.sel_in = 3;
    tick;
    chk8("load3", 'hB, 3, 1, 0);
    b8.load = 0;
    b8.A[3*4 +: 4] = 4'h2;
    tick;
    chk8("data_follow", 'h2, 3, 1, 0);
    b8.A[3*4 +: 4] = 4'hB;

    // scan wrap from 0
    b8.load = 1; b8.sel_in = 0;
    tick;
    chk8("load0", 'h8, 0, 1, 0);
    b8.load = 0; b8.mode = MODE_SCAN; b8.step = 1;
    for (int i = 0; i < 9; i++) begin
      int s;
      s = (i + 1) % 8;
      tick;
      chk8($sformatf("scan%0d", i), s + 8, s, 1, (s == 0) ? 1 : 0);
    end

    // hold beats step and load; A change is not sampled while frozen
    b8.hold = 1; b8.load = 1; b8.sel_in = 5;
    b8.A[1*4 +: 4] = 4'h0;
    for (int i = 0; i < 3; i++) begin
      tick;
      chk8($sformatf("hold%0d", i), 'h9, 1, 1, 0);
    end
    b8.A[1*4 +: 4] = 4'h9;
    b8.hold = 0; b8.load = 0;
    tick;
    chk8("hold_release", 'hA, 2, 1, 0);
    b8.step = 0;
    tick;
    chk8("scan_idle", 'hA, 2, 1, 0);

    // mode switch keeps the select register
    b8.mode = MODE_MANUAL; b8.load = 1; b8.sel_in = 6;
    tick;
    chk8("sw_load6", 'hE, 6, 1, 0);
    b8.mode = MODE_SCAN; b8.step = 1;
    tick;
    chk8("sw_step7", 'hF, 7, 1, 0);
    tick;
    chk8("sw_wrap", 'h8, 0, 1, 1);
    b8.mode = MODE_MANUAL; b8.load = 0;
    tick;
    chk8("sw_manual_step", 'h8, 0, 1, 0);
    b8.step = 0;

    // non-power-of-two channel count
    b5.mode = MODE_SCAN; b5.step = 1;
    for (int i = 0; i < 5; i++) begin
      int s;
      s = (i + 1) % 5;
      tick;
      chk5($sformatf("n5_scan%0d", i), s + 1, s, (s == 0) ? 1 : 0, 0);
    end
    b5.mode = MODE_MANUAL; b5.step = 0; b5.load = 1; b5.sel_in = 6;
    tick;
    chk5("n5_load6", 1, 0, 0, 1);
    b5.load = 0;
    tick;
    chk5("n5_err_clear", 1, 0, 0, 0);
    b5.load = 1; b5.sel_in = 4;
    tick;
    chk5("n5_load4", 5, 4, 0, 0);
    b5.sel_in = 5;
    tick;
    chk5("n5_load5", 5, 4, 0, 1);
    b5.load = 0;

    // async reset in the middle of a scan
    b8.load = 1; b8.sel_in = 0;
    tick;
    b8.load = 0; b8.mode = MODE_SCAN; b8.step = 1;
    repeat (5) tick;
    chk8("pre_rst", 'hD, 5, 1, 0);
    rst = 1'b1;
    #1;
    chk8("mid_rst", 0, 0, 0, 0);
    b8.step = 0;
    @(negedge clk);
    rst = 1'b0;
    tick;
    chk8("post_rst", 'h8, 0, 1, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/scan_mux_n1.md
Name: scan_mux_n1

Overview:
- Parametrised N:1 multiplexer with a registered output and an internal select register; successor to the combinational 8:1 selector.
- Two modes:
  - MANUAL: select is loaded from a port.
  - SCAN: select auto-steps through channels on a step strobe, for time-division sampling of N sources onto one bus.
- Sits between the parallel source bank and a single downstream consumer, e.g. display driver or serialiser.

Parameters:
- N_CH, 8, number of input channels; legal range 2..64, need not be a power of two.
- W, 1, data width per channel in bits.
- SEL_W, $clog2(N_CH), select width; derived, not overridden.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous active-high reset.
- mode  in  1  0 = MANUAL, 1 = SCAN; sampled every cycle.
- sel_in  in  SEL_W  channel index to load in MANUAL mode.
- load  in  1  MANUAL: capture sel_in into the select register.
- step  in  1  SCAN: advance the select register by one.
- hold  in  1  freeze the select register and dout; highest priority.
- A  in  N_CH*W  packed inputs; channel k occupies A[k*W +: W].
- F  out  W  registered selected data.
- sel_out  out  SEL_W  channel index that produced the current F.
- valid  out  1  F holds a selected sample; low from reset until the first update.
- wrap  out  1  one-cycle pulse when SCAN steps from N_CH-1 to 0.
- sel_err  out  1  one-cycle pulse when load presents sel_in >= N_CH.

Behaviour:
- Reset (async, rst=1): sel register=0, F=0, sel_out=0, valid=0, wrap=0, sel_err=0. All outputs return to these values within the same cycle rst asserts, including mid-scan. First edge after rst deasserts acts as a normal cycle.
- Per-edge priority, evaluated in order:
  1. hold=1: sel register, F, sel_out and valid unchanged; wrap=0, sel_err=0. load and step are ignored, not queued.
  2. MANUAL with load=1 and sel_in < N_CH: sel register <= sel_in.
  3. MANUAL with load=1 and sel_in >= N_CH: sel register unchanged; sel_err=1 for one cycle.
  4. SCAN with step=1: sel register <= sel_reg+1, or 0 if sel_reg == N_CH-1, in which case wrap=1 for one cycle.
  5. Otherwise the sel register is unchanged.
- In SCAN mode, load is ignored. In MANUAL mode, step is ignored.
- Output path, latency 1:
  - On every non-hold edge: F <= A[next_sel*W +: W], where next_sel is the post-update select value; also sel_out <= next_sel and valid <= 1.
  - F therefore reflects the newly loaded or stepped channel on the same edge, sampling A at that edge.
  - A changes while the select is static appear on F one cycle later.
- Mode switch: changing mode does not alter the sel register. Scanning resumes from the manually loaded index; MANUAL keeps the last scanned index.
- Simultaneous load and step: resolved by the current mode; the other strobe has no effect.
- Non-power-of-two N_CH:
  - Indices N_CH..2^SEL_W-1 are never reached in SCAN.
  - These indices are rejected by load in MANUAL.
  - F is never driven from out-of-range bits.
- wrap and sel_err are never high in the same cycle.

Decomposition:
- Shared package: mode constants MODE_MANUAL=1'b0, MODE_SCAN=1'b1.
- One sub-module, sel_counter:
  - Holds the select register and the load/step/hold/wrap logic, parametrised by N_CH.
  - Outputs next_sel, wrap and sel_err.
- The top level holds the data mux and output registers.

Test Plan:
- Reset mid-scan: N_CH=8, W=4, SCAN, step every cycle, assert rst at sel=5 -> F=0, sel_out=0, valid=0 immediately, without waiting for a clock edge.
- MANUAL load: A = channel k holds value k+8 (W=4), load sel_in=3 -> next edge F=4'hB, sel_out=3, valid=1. Change channel 3 to 4'h2 with no load -> F=4'h2 one cycle later.
- SCAN wrap: N_CH=8, step held high for 9 cycles from sel=0 -> sel_out sequence 1..7,0,1; wrap high only on the cycle sel_out becomes 0.
- Non-power-of-two: N_CH=5, SCAN steps -> sel_out 1,2,3,4,0 with wrap on the 0. MANUAL load sel_in=6 -> sel_err pulses, sel_out unchanged.
- Hold priority: hold=1 with step=1 and load=1 for 3 cycles -> F and sel_out frozen, wrap=0, sel_err=0. Release hold with step=1 -> single advance.
- Mode switch: MANUAL load 6, switch to SCAN, step twice -> sel_out 7, then 0 with wrap. Switch to MANUAL with step=1 -> sel_out stays 0.
